// File: rtl/gray_cnt_pkg.sv
// Shared types and helpers for the Gray-code counter slice.
// gray2bin is provided for consumers and benches; the RTL uses only the encoder.
package gray_cnt_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned CNT_MAX   = 2**DEF_WIDTH - 1;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Binary bit i is the XOR of all Gray bits at or above i.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = '0;
    for (int unsigned k = 0; k < 32; k++) begin
      b = b ^ (g >> k);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_code_counter_gray_enc.sv
// Combinational WIDTH-bit binary to Gray encoder.
module gray_enc #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/gray_code_counter.sv
// Registered up/down counter with Gray and binary outputs over a valid/ready handshake.
// Define GRAY_CNT_SAT_EN to saturate at the range ends instead of wrapping.
module gray_code_counter
  import gray_cnt_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] gray_o,
  output logic [WIDTH-1:0] bin_o,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic [WIDTH-1:0] step_val;
  logic             valid_q, valid_d;
  logic             tc_q, tc_d;
  logic             wrap_q, wrap_d;
  logic             slot_free;
  logic             at_end;
  dir_e             dir;

  assign dir       = dir_e'(up);
  assign slot_free = !valid_q || out_ready;
  assign at_end    = (dir == DIR_UP) ? (bin_q == '1) : (bin_q == '0);
  assign step_val  = (dir == DIR_UP) ? (bin_q + 1'b1) : (bin_q - 1'b1);

  always_comb begin
    bin_d   = bin_q;
    valid_d = valid_q;
    wrap_d  = 1'b0;
    if (ld) begin
      bin_d   = ld_val;
      valid_d = 1'b1;
    end else if (en && slot_free) begin
      valid_d = 1'b1;
`ifdef GRAY_CNT_SAT_EN
      if (!at_end) begin
        bin_d = step_val;
      end
`else
      bin_d  = step_val;
      wrap_d = at_end;
`endif
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
    tc_d = (dir == DIR_UP) ? (bin_d == '1) : (bin_d == '0);
  end

  gray_enc #(.WIDTH(WIDTH)) u_gray_enc (
    .bin_i  (bin_d),
    .gray_o (gray_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q   <= RST_BIN;
      gray_q  <= RST_GRAY;
      valid_q <= 1'b0;
      tc_q    <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      valid_q <= valid_d;
      tc_q    <= tc_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bin_o     = bin_q;
  assign gray_o    = gray_q;
  assign out_valid = valid_q;
  assign tc        = tc_q;
  assign wrap      = wrap_q;

endmodule
